// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised register file with a per-register pending-write scoreboard.
//   Decode reads operands and reserves destinations; writeback writes data
//   and retires the reservation. rd_busy flags a RAW hazard on a read port.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   rd_addr/rd_data   NRD packed read ports (combinational read)
//   rd_busy           per-port pending-write flag for the addressed register
//   wr_en/addr/data   writeback port; also clears the register's busy bit
//   rsv_en/rsv_addr   mark a destination register pending at issue
//   flush             synchronous clear of every pending mark
//   busy_count        registered popcount of the busy vector

// One read port: applies the zero-register and bypass overrides to the
// stored value selected by the parent.
module regfile_scoreboard_rd #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            reg_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] data,
    output logic            busy
);
    always_comb begin
        data = reg_data;
        busy = reg_busy;
        if (ZERO_REG != 0 && addr == '0) begin
            data = '0;
            busy = 1'b0;
        end else if (BYPASS != 0 && wr_en && wr_addr == addr) begin
            // the producer is completing this cycle, so the hazard is gone
            data = wr_data;
            busy = 1'b0;
        end
    end
endmodule

module regfile_scoreboard #(
    parameter int   XLEN     = 32,
    parameter int   NREGS    = 32,
    parameter int   NRD      = 2,
    parameter int   ZERO_REG = 1,
    parameter int   BYPASS   = 1,
    localparam int  AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    output logic [AW:0]         busy_count
);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      count_nxt;
    logic             wr_ok;
    logic             rsv_ok;

    // register 0 is neither writable nor reservable when hardwired to zero
    assign wr_ok  = wr_en  && (ZERO_REG == 0 || wr_addr  != '0);
    assign rsv_ok = rsv_en && (ZERO_REG == 0 || rsv_addr != '0);

    // Order matters: flush, then writeback clear, then reservation. A new
    // producer reserved in the same cycle supersedes the retiring one.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (wr_ok)
            busy_nxt[wr_addr] = 1'b0;
        if (rsv_ok)
            busy_nxt[rsv_addr] = 1'b1;
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_ok)
                regs[wr_addr] <= wr_data;
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[k*AW +: AW];

        regfile_scoreboard_rd #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .addr     (addr),
            .reg_data (regs[addr]),
            .reg_busy (busy[addr]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[k*XLEN +: XLEN]),
            .busy     (rd_busy[k])
        );
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Three builds share clock/reset: default (bypass), no-bypass (same
//   stimulus as default), and a wide 3-port 64-bit 16-register build.
//   Expected values are queued as stimulus is driven and drained/compared
//   once the outputs have settled.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default and no-bypass builds share these inputs
    logic [9:0]  rd_addr;
    logic        wr_en, rsv_en, flush;
    logic [4:0]  wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic [63:0] d_rd_data, n_rd_data;
    logic [1:0]  d_rd_busy, n_rd_busy;
    logic [5:0]  d_busy_count, n_busy_count;

    // wide build
    logic [11:0]  w_rd_addr;
    logic         w_wr_en, w_rsv_en, w_flush;
    logic [3:0]   w_wr_addr, w_rsv_addr;
    logic [63:0]  w_wr_data;
    logic [191:0] w_rd_data;
    logic [2:0]   w_rd_busy;
    logic [4:0]   w_busy_count;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(d_rd_data),
        .rd_busy(d_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .busy_count(d_busy_count));

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(n_rd_data),
        .rd_busy(n_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .busy_count(n_busy_count));

    regfile_scoreboard #(.XLEN(64), .NREGS(16), .NRD(3)) dut_w (
        .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
        .rd_busy(w_rd_busy), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
        .wr_data(w_wr_data), .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr),
        .flush(w_flush), .busy_count(w_busy_count));

    // observation selectors
    localparam int D_DATA = 0, D_BUSY = 1, D_CNT = 2;
    localparam int N_DATA = 3, N_BUSY = 4, N_CNT = 5;
    localparam int W_DATA = 6, W_CNT  = 7;

    typedef struct {
        string       tag;
        int          sel;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input int sel, input int port, input logic [63:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] observe(input int sel, input int port);
        case (sel)
            D_DATA:  return {32'h0, d_rd_data[port*32 +: 32]};
            D_BUSY:  return {63'h0, d_rd_busy[port]};
            D_CNT:   return {58'h0, d_busy_count};
            N_DATA:  return {32'h0, n_rd_data[port*32 +: 32]};
            N_BUSY:  return {63'h0, n_rd_busy[port]};
            N_CNT:   return {58'h0, n_busy_count};
            W_DATA:  return w_rd_data[port*64 +: 64];
            default: return {59'h0, w_busy_count};
        endcase
    endfunction

    // settle combinational paths, then compare everything queued
    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel, e.port), e.exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en = 0; rsv_en = 0; flush = 0;
    endtask

    initial begin
        rst = 1; idle(); wr_addr = 0; wr_data = 0; rsv_addr = 0; rd_addr = 0;
        w_wr_en = 0; w_rsv_en = 0; w_flush = 0; w_wr_addr = 0; w_rsv_addr = 0;
        w_wr_data = 0; w_rd_addr = 0;
        repeat (2) @(negedge clk);

        // reset state across every register on both ports
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            push("rst_data0", D_DATA, 0, 0);
            push("rst_data1", D_DATA, 1, 0);
            push("rst_busy0", D_BUSY, 0, 0);
            push("rst_busy1", D_BUSY, 1, 0);
            drain();
        end
        push("rst_cnt", D_CNT, 0, 0);
        push("rst_w_cnt", W_CNT, 0, 0);
        drain();

        // reset asserted mid-write discards the write
        @(negedge clk) rst = 0;
        @(negedge clk) begin wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; end
        #2 rst = 1;
        @(negedge clk) begin idle(); rst = 0; set_rd(5, 5); end
        push("rst_midwr_x5", D_DATA, 0, 0);
        push("rst_midwr_x5_nb", N_DATA, 0, 0);
        drain();

        // write to x0 is ignored
        @(negedge clk) begin wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; end
        @(negedge clk) begin idle(); set_rd(0, 0); end
        push("x0_zero", D_DATA, 0, 0);
        drain();

        // write x31, visible next cycle
        @(negedge clk) begin wr_en = 1; wr_addr = 31; wr_data = 32'hCAFEF00D; end
        @(negedge clk) begin idle(); set_rd(31, 0); end
        push("x31_rd", D_DATA, 0, 32'hCAFEF00D);
        drain();

        // same-cycle bypass vs no bypass
        @(negedge clk) begin wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; set_rd(7, 7); end
        push("byp_x7", D_DATA, 0, 32'hA5A5A5A5);
        push("byp_x7_p1", D_DATA, 1, 32'hA5A5A5A5);
        push("nobyp_x7_old", N_DATA, 0, 0);
        drain();
        @(negedge clk) idle();
        push("nobyp_x7_new", N_DATA, 0, 32'hA5A5A5A5);
        drain();

        // reserve x3
        @(negedge clk) begin rsv_en = 1; rsv_addr = 3; end
        @(negedge clk) begin idle(); set_rd(3, 0); end
        push("rsv_x3_busy", D_BUSY, 0, 1);
        push("rsv_x3_cnt", D_CNT, 0, 1);
        push("rsv_x0_busy", D_BUSY, 1, 0);
        drain();

        // writeback x3: bypass hides hazard at once, no-bypass keeps stored busy
        @(negedge clk) begin wr_en = 1; wr_addr = 3; wr_data = 32'h42; end
        push("wb_x3_byp_busy", D_BUSY, 0, 0);
        push("wb_x3_byp_data", D_DATA, 0, 32'h42);
        push("wb_x3_nb_busy", N_BUSY, 0, 1);
        drain();
        @(negedge clk) idle();
        push("wb_x3_busy", D_BUSY, 0, 0);
        push("wb_x3_cnt", D_CNT, 0, 0);
        push("wb_x3_data", D_DATA, 0, 32'h42);
        push("wb_x3_nb_cnt", N_CNT, 0, 0);
        drain();

        // reserve and write x3 together: data lands, busy stays set
        @(negedge clk) begin wr_en = 1; wr_addr = 3; wr_data = 32'h77; rsv_en = 1; rsv_addr = 3; end
        @(negedge clk) idle();
        push("rw_x3_data", D_DATA, 0, 32'h77);
        push("rw_x3_busy", D_BUSY, 0, 1);
        push("rw_x3_cnt", D_CNT, 0, 1);
        drain();

        // retire x3, then reserve x1, x2, x4
        @(negedge clk) begin wr_en = 1; wr_addr = 3; wr_data = 32'h78; end
        @(negedge clk) begin idle(); rsv_en = 1; rsv_addr = 1; end
        @(negedge clk) rsv_addr = 2;
        @(negedge clk) rsv_addr = 4;
        @(negedge clk) idle();
        push("rsv3_cnt", D_CNT, 0, 3);
        drain();

        // flush + reserve x9, with a write to x10 in the same cycle
        @(negedge clk) begin flush = 1; rsv_en = 1; rsv_addr = 9; wr_en = 1; wr_addr = 10; wr_data = 32'h1010; end
        @(negedge clk) begin idle(); set_rd(9, 1); end
        push("flush_cnt", D_CNT, 0, 1);
        push("flush_x9_busy", D_BUSY, 0, 1);
        push("flush_x1_busy", D_BUSY, 1, 0);
        drain();
        set_rd(10, 4);
        push("flush_wr_x10", D_DATA, 0, 32'h1010);
        push("flush_x4_busy", D_BUSY, 1, 0);
        drain();

        // wide build: three identical ports, x0 not reservable
        @(negedge clk) begin w_wr_en = 1; w_wr_addr = 15; w_wr_data = 64'hFFFF0000FFFF0000; end
        @(negedge clk) begin w_wr_en = 0; w_rd_addr = {4'd15, 4'd15, 4'd15}; end
        for (int p = 0; p < 3; p++) push($sformatf("w_x15_p%0d", p), W_DATA, p, 64'hFFFF0000FFFF0000);
        drain();
        @(negedge clk) begin w_rsv_en = 1; w_rsv_addr = 0; end
        @(negedge clk) w_rsv_en = 0;
        push("w_rsv_x0_cnt", W_CNT, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 32x32 register file.
- Generalised width, depth and read-port count; optional hardwired zero register; optional write-to-read bypass.
- Adds a per-register pending-write scoreboard so the pipelined femtoRV32 core can detect RAW hazards without an external hazard table.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, >= 2. Localparam AW = $clog2(NREGS).
- NRD, 2, number of independent read ports, >= 1.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, is never busy.
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- rd_addr  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  output  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rd_busy  output  NRD  port k's register has an outstanding reserved write.
- wr_en  input  1  writeback enable.
- wr_addr  input  AW  writeback register.
- wr_data  input  XLEN  writeback data.
- rsv_en  input  1  reserve (mark pending) a destination register at issue.
- rsv_addr  input  AW  register to reserve.
- flush  input  1  synchronous clear of all pending marks (pipeline flush).
- busy_count  output  AW+1  number of registers currently marked pending.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers become 0 and all busy bits become 0.
  - Outputs under reset: busy_count = 0, rd_busy = 0, rd_data = 0 (or the bypass value if BYPASS and wr_en are active).
  - Reset mid-operation discards any write or reserve presented in that cycle.
- Write:
  - On posedge clk, if wr_en and the target is writable, regs[wr_addr] <= wr_data.
  - Writable means ZERO_REG = 0, or wr_addr != 0.
  - The write clears busy[wr_addr].
  - Write to register 0 with ZERO_REG = 1 has no effect.
- Read (combinational, zero latency), per port k:
  - If ZERO_REG and rd_addr_k == 0: rd_data_k = 0 and rd_busy_k = 0.
  - Else if BYPASS, wr_en and wr_addr == rd_addr_k: rd_data_k = wr_data and rd_busy_k = 0.
  - Else: rd_data_k = regs[rd_addr_k] and rd_busy_k = busy[rd_addr_k].
  - With BYPASS = 0, a same-cycle write is visible on the read port only from the next cycle, and rd_busy stays as stored.
- Reserve:
  - On posedge clk, if rsv_en and rsv_addr is writable, busy[rsv_addr] <= 1.
  - Reserving an already-busy register leaves it busy; there is no counting of multiple producers.
- Simultaneous events on the same register in one cycle:
  - rsv_en and wr_en on the same register: the data is written and busy ends at 1, because a new producer supersedes the old one.
  - flush and rsv_en together: flush clears every busy bit, then the reservation is applied, so busy[rsv_addr] = 1 after the edge.
  - flush does not block the write; wr_en still writes data.
- Multiple read ports may address the same register; each returns identical values.
- busy_count:
  - Registered; equals the popcount of the busy vector after each edge.
  - Range 0..NREGS (0..NREGS-1 when ZERO_REG = 1).
  - Updated in the same edge as the busy bits.
- No X propagation: every register and busy bit is defined from reset onward.

Test Plan:
- Reset then read all registers on both ports -> every rd_data = 0x00000000, rd_busy = 0, busy_count = 0; assert rst mid-write of 0xDEADBEEF to x5 -> x5 still reads 0.
- Write 0x12345678 to x0 with ZERO_REG = 1 -> x0 reads 0; write 0xCAFEF00D to x31 -> read of x31 on port 0 returns 0xCAFEF00D the next cycle.
- BYPASS = 1: same cycle wr_en to x7 with 0xA5A5A5A5 and rd_addr0 = 7 -> rd_data0 = 0xA5A5A5A5 combinationally; repeat with BYPASS = 0 -> old value, new value one cycle later.
- Reserve x3 -> rd_busy = 1 and busy_count = 1; write x3 with 0x00000042 -> busy clears and busy_count = 0; reserve and write x3 in the same cycle -> x3 = data and busy stays 1.
- Reserve x1, x2, x4 over 3 cycles (busy_count = 3); flush together with rsv x9 -> busy_count = 1 with only x9 busy.
- NRD = 3, XLEN = 64, NREGS = 16 build: all three ports read x15 = 0xFFFF0000FFFF0000 identically; a reserve of x0 leaves busy_count at 0.
